// File: rtl/count_event_monitor.sv
// count_event_monitor: detects compare-match and wrap events on a sampled counter bus
// Ports:
//   Clock, Reset         rising-edge clock, asynchronous active-high reset
//   Count                counter value sampled every edge
//   Compare, CompareWe   new compare value and its load strobe
//   Ack                  clears sticky flags and the wrap tally
//   Match, Wrap          one-cycle event pulses
//   MatchFlag, WrapFlag  sticky event flags
//   Irq                  registered OR of the sticky flags
//   WrapCount            saturating wrap tally since the last Ack or reset
module count_event_monitor #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Count,
  input  logic [WIDTH-1:0] Compare,
  input  logic             CompareWe,
  input  logic             Ack,
  output logic             Match,
  output logic             Wrap,
  output logic             MatchFlag,
  output logic             WrapFlag,
  output logic             Irq,
  output logic [WIDTH-1:0] WrapCount
);
  typedef enum logic {ARM, RUN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] prev_count, cmp_reg;
  logic match_ev, wrap_ev;
  always_comb begin
    state_n  = state;
    match_ev = 1'b0;
    wrap_ev  = 1'b0;
    if (state == ARM) state_n = RUN;
    // ARM only primes prev_count so the counter's own reset release cannot look like an event
    if (state == RUN) begin
      match_ev = (Count == cmp_reg) && (Count != prev_count);
      wrap_ev  = (prev_count == '1) && (Count == '0);
    end
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ARM;
    else       state <= state_n;
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      prev_count <= '0;
      cmp_reg    <= '1;
      Match      <= 1'b0;
      Wrap       <= 1'b0;
      MatchFlag  <= 1'b0;
      WrapFlag   <= 1'b0;
      Irq        <= 1'b0;
      WrapCount  <= '0;
    end else begin
      prev_count <= Count;
      cmp_reg    <= CompareWe ? Compare : cmp_reg;
      Match      <= match_ev;
      Wrap       <= wrap_ev;
      // an event on the Ack edge wins over the clear
      MatchFlag  <= match_ev | (MatchFlag & ~Ack);
      WrapFlag   <= wrap_ev | (WrapFlag & ~Ack);
      Irq        <= MatchFlag | WrapFlag;
      WrapCount  <= wrap_ev ? (Ack ? WIDTH'(1) : WrapCount + WIDTH'(WrapCount != '1))
                            : (Ack ? '0 : WrapCount);
    end
  end
endmodule

// File: tb/tb_count_event_monitor.sv
// tb_count_event_monitor: directed self-checking bench for count_event_monitor
module tb_count_event_monitor;
  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] Count;
  logic [7:0] Compare;
  logic       CompareWe;
  logic       Ack;
  logic       Match, Wrap, MatchFlag, WrapFlag, Irq;
  logic [7:0] WrapCount;
  int errors = 0;
  int checks = 0;

  count_event_monitor #(.WIDTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .Count(Count), .Compare(Compare),
    .CompareWe(CompareWe), .Ack(Ack), .Match(Match), .Wrap(Wrap),
    .MatchFlag(MatchFlag), .WrapFlag(WrapFlag), .Irq(Irq), .WrapCount(WrapCount)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Count = 8'h00; Compare = 8'h00; CompareWe = 1'b0; Ack = 1'b0;
    #3;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    Reset = 1'b1; Count = 8'h00; Compare = 8'h00; CompareWe = 1'b0; Ack = 1'b0;
    #2;
    got = {Match, Wrap, MatchFlag, WrapFlag, Irq, WrapCount};
    checks++;
    if (got !== 13'h0) begin errors++; $display("FAIL reset_outputs: got %h want 0", got); end
    tick();
    Reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({Match, Wrap} !== 2'b00) begin errors++; $display("FAIL reset_hold_no_pulse: got %b want 00", {Match, Wrap}); end
    // reset CmpReg is 0xFF: jumping 0x00 -> 0xFF must match and also proves RUN
    Count = 8'hFF;
    tick();
    checks++;
    if (Match !== 1'b1) begin errors++; $display("FAIL reset_cmp_ff: Match got %b want 1", Match); end
  endtask

  task automatic test_match();
    do_reset();
    Compare = 8'h05; CompareWe = 1'b1;
    tick();
    CompareWe = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      Count = 8'(i);
      tick();
      checks++;
      if (Match !== (i == 5)) begin errors++; $display("FAIL match_pulse i=%0d: got %b want %b", i, Match, i == 5); end
      checks++;
      if (MatchFlag !== (i >= 5)) begin errors++; $display("FAIL match_flag i=%0d: got %b want %b", i, MatchFlag, i >= 5); end
      checks++;
      if (Irq !== (i >= 6)) begin errors++; $display("FAIL match_irq i=%0d: got %b want %b", i, Irq, i >= 6); end
    end
  endtask

  task automatic test_hold_ack();
    Count = 8'h05;
    tick();
    checks++;
    if (Match !== 1'b1) begin errors++; $display("FAIL hold_first: Match got %b want 1", Match); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (Match !== 1'b0) begin errors++; $display("FAIL hold_repeat %0d: Match got %b want 0", i, Match); end
    end
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    checks++;
    if ({MatchFlag, Irq} !== 2'b01) begin errors++; $display("FAIL ack_edge: flag,irq got %b want 01", {MatchFlag, Irq}); end
    tick();
    checks++;
    if ({MatchFlag, Irq} !== 2'b00) begin errors++; $display("FAIL ack_after: flag,irq got %b want 00", {MatchFlag, Irq}); end
  endtask

  task automatic test_wrap();
    int pulses = 0;
    do_reset();
    tick();
    for (int n = 1; n <= 768; n++) begin
      Count = 8'(n);
      tick();
      pulses += int'(Wrap);
      checks++;
      if (Wrap !== (n % 256 == 0)) begin errors++; $display("FAIL wrap_pulse n=%0d: got %b want %b", n, Wrap, n % 256 == 0); end
    end
    checks++;
    if (pulses != 3) begin errors++; $display("FAIL wrap_pulses: got %0d want 3", pulses); end
    checks++;
    if (WrapCount !== 8'h03) begin errors++; $display("FAIL wrap_count3: got %h want 03", WrapCount); end
    for (int n = 0; n < 300; n++) begin
      Count = 8'hFF;
      tick();
      Count = 8'h00;
      tick();
    end
    checks++;
    if (WrapCount !== 8'hFF) begin errors++; $display("FAIL wrap_saturate: got %h want ff", WrapCount); end
    checks++;
    if ({WrapFlag, Irq} !== 2'b11) begin errors++; $display("FAIL wrap_flag_irq: got %b want 11", {WrapFlag, Irq}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick();
    for (int n = 0; n < 7; n++) begin
      Count = 8'hFF;
      tick();
      Count = 8'h00;
      tick();
    end
    checks++;
    if (WrapCount !== 8'h07) begin errors++; $display("FAIL pre_ack_count: got %h want 07", WrapCount); end
    Count = 8'hFF;
    tick();
    Count = 8'h00; Ack = 1'b1;
    tick();
    Ack = 1'b0;
    checks++;
    if ({Wrap, WrapFlag} !== 2'b11) begin errors++; $display("FAIL ack_wrap_flag: got %b want 11", {Wrap, WrapFlag}); end
    checks++;
    if (WrapCount !== 8'h01) begin errors++; $display("FAIL ack_wrap_count: got %h want 01", WrapCount); end
    Count = 8'hFF;
    tick();
    Count = 8'h00; Compare = 8'h00; CompareWe = 1'b1;
    tick();
    CompareWe = 1'b0;
    checks++;
    if ({Match, Wrap} !== 2'b01) begin errors++; $display("FAIL we_old_cmp: match,wrap got %b want 01", {Match, Wrap}); end
    Count = 8'h01;
    tick();
    Count = 8'h00;
    tick();
    checks++;
    if ({Match, Wrap} !== 2'b10) begin errors++; $display("FAIL new_cmp: match,wrap got %b want 10", {Match, Wrap}); end
    Count = 8'hFF;
    tick();
    Count = 8'h00;
    tick();
    checks++;
    if ({Match, Wrap, MatchFlag, WrapFlag} !== 4'b1111) begin
      errors++; $display("FAIL both_events: got %b want 1111", {Match, Wrap, MatchFlag, WrapFlag});
    end
  endtask

  task automatic test_async_reset();
    logic [12:0] got;
    do_reset();
    Compare = 8'h05; CompareWe = 1'b1;
    tick();
    CompareWe = 1'b0; Count = 8'h05;
    tick();
    checks++;
    if (Match !== 1'b1) begin errors++; $display("FAIL async_pre: Match got %b want 1", Match); end
    #2;
    Reset = 1'b1;
    #1;
    got = {Match, Wrap, MatchFlag, WrapFlag, Irq, WrapCount};
    checks++;
    if (got !== 13'h0) begin errors++; $display("FAIL async_clear: got %h want 0", got); end
    #1;
    Reset = 1'b0;
    Count = 8'hFF;
    tick();
    checks++;
    if (Match !== 1'b0) begin errors++; $display("FAIL rearm_suppress: Match got %b want 0", Match); end
    Count = 8'h00;
    tick();
    checks++;
    if (Wrap !== 1'b1) begin errors++; $display("FAIL rearm_run: Wrap got %b want 1", Wrap); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_hold_ack();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
